// File: rtl/otbn_keccak_lane_collector_if.sv
// Lane-collector bus bundle: lane input stream, flush, drain output stream and status.
interface otbn_keccak_lane_collector_if #(
  parameter int unsigned WordW = 256
);
  logic             in_valid;
  logic             in_ready;
  logic [WordW-1:0] in_data;
  logic [1:0]       in_d_w_sel;
  logic [2:0]       in_x;
  logic [2:0]       in_y;
  logic             in_pi;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WordW-1:0] out_data;
  logic             out_last;
  logic [4:0]       lane_cnt;
  logic             err;

  modport master (
    output in_valid, in_data, in_d_w_sel, in_x, in_y, in_pi, flush, out_ready,
    input  in_ready, out_valid, out_data, out_last, lane_cnt, err
  );

  modport slave (
    input  in_valid, in_data, in_d_w_sel, in_x, in_y, in_pi, flush, out_ready,
    output in_ready, out_valid, out_data, out_last, lane_cnt, err
  );
endinterface

// File: rtl/otbn_keccak_lane_collector.sv
// Collects 25 Keccak lanes (optionally pi-remapped) and drains them as seven packed words.
// Optional macro OTBN_KECCAK_COLLECT_CHI_EN: drain chi(state) instead of the raw buffer.
module otbn_keccak_lane_collector #(
  parameter int unsigned LaneW        = 64,
  parameter int unsigned WordW        = 256,
  parameter bit          ClearOnDrain = 1'b1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  otbn_keccak_lane_collector_if.slave bus
);

  localparam int unsigned NumLanes     = 25;
  localparam int unsigned LanesPerWord = 4;
  localparam int unsigned LastWord     = 6;

  typedef enum logic {
    COLLECT,
    DRAIN
  } state_e;

  state_e                  state_q, state_d;
  logic [NumLanes-1:0]     bitmap_q, bitmap_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [2:0]              beat_q, beat_d;
  logic                    err_q, err_d;
  logic                    wr_en;
  logic                    clr_buf;
  logic                    coord_ok;
  logic [2:0]              dst_x;
  logic [2:0]              dst_y;
  logic [4:0]              pi_sum;
  logic [4:0]              wr_idx;
  logic [LaneW-1:0]        wr_lane;
  logic [LaneW-1:0]        lanes_q   [NumLanes];
  logic [LaneW-1:0]        src_lanes [NumLanes];
  logic [WordW-1:0]        out_word;

  // Destination lane: pi maps (x,y) -> (y, (2x+3y) mod 5); range check uses raw coordinates.
  always_comb begin
    coord_ok = (bus.in_x <= 3'd4) && (bus.in_y <= 3'd4);
    pi_sum   = 5'(bus.in_x) * 5'd2 + 5'(bus.in_y) * 5'd3;
    dst_x    = bus.in_pi ? bus.in_y : bus.in_x;
    dst_y    = bus.in_pi ? 3'(pi_sum % 5'd5) : bus.in_y;
    wr_idx   = 5'(dst_x) + 5'(dst_y) * 5'd5;
    wr_lane  = bus.in_data[{bus.in_d_w_sel, 6'd0} +: LaneW];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= COLLECT;
      bitmap_q <= '0;
      cnt_q    <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitmap_q <= bitmap_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic; flush overrides any handshake in the same cycle.
  always_comb begin
    state_d  = state_q;
    bitmap_d = bitmap_q;
    cnt_d    = cnt_q;
    beat_d   = beat_q;
    err_d    = 1'b0;
    wr_en    = 1'b0;
    clr_buf  = 1'b0;
    if (bus.flush) begin
      state_d  = COLLECT;
      bitmap_d = '0;
      cnt_d    = '0;
      beat_d   = '0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (bus.in_valid) begin
            if (!coord_ok) begin
              err_d = 1'b1;
            end else begin
              wr_en            = 1'b1;
              bitmap_d[wr_idx] = 1'b1;
              if (!bitmap_q[wr_idx]) begin
                cnt_d = cnt_q + 5'd1;
              end
              if (cnt_d == 5'(NumLanes)) begin
                state_d = DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            if (beat_q == 3'(LastWord)) begin
              state_d  = COLLECT;
              bitmap_d = '0;
              cnt_d    = '0;
              beat_d   = '0;
              clr_buf  = ClearOnDrain;
            end else begin
              beat_d = beat_q + 3'd1;
            end
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumLanes; i++) lanes_q[i] <= '0;
    end else if (clr_buf) begin
      for (int i = 0; i < NumLanes; i++) lanes_q[i] <= '0;
    end else if (wr_en) begin
      lanes_q[wr_idx] <= wr_lane;
    end
  end

`ifdef OTBN_KECCAK_COLLECT_CHI_EN
  // chi: A[x,y] ^ (~A[x+1,y] & A[x+2,y]) along each row.
  always_comb begin
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        src_lanes[x + 5*y] = lanes_q[x + 5*y]
                           ^ (~lanes_q[(x + 1) % 5 + 5*y] & lanes_q[(x + 2) % 5 + 5*y]);
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NumLanes; i++) src_lanes[i] = lanes_q[i];
  end
`endif

  // Word k packs lanes 4k..4k+3, lane 4k in the LSBs; lanes past 24 read as zero.
  always_comb begin
    logic [4:0] li;
    out_word = '0;
    li       = '0;
    for (int j = 0; j < LanesPerWord; j++) begin
      li = {beat_q, 2'b00} + 5'(j);
      if (li < 5'(NumLanes)) begin
        out_word[j*LaneW +: LaneW] = src_lanes[li];
      end
    end
  end

  assign bus.in_ready  = (state_q == COLLECT);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.out_last  = (state_q == DRAIN) && (beat_q == 3'(LastWord));
  assign bus.out_data  = out_word;
  assign bus.lane_cnt  = cnt_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_otbn_keccak_lane_collector.sv
// Directed scoreboard bench for otbn_keccak_lane_collector (honours OTBN_KECCAK_COLLECT_CHI_EN).
module tb_otbn_keccak_lane_collector;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  otbn_keccak_lane_collector_if #(.WordW(256)) bus ();

  otbn_keccak_lane_collector dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;
  logic [63:0]  mdl [25];
  bit           mbm [25];
  int           mcnt = 0;
  logic [255:0] exp_q[$];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] model_lane(input int i);
`ifdef OTBN_KECCAK_COLLECT_CHI_EN
    int x, y;
    x = i % 5;
    y = i / 5;
    return mdl[i] ^ (~mdl[(x + 1) % 5 + 5*y] & mdl[(x + 2) % 5 + 5*y]);
`else
    return mdl[i];
`endif
  endfunction

  function automatic logic [255:0] model_word(input int k);
    logic [255:0] w;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      if (4*k + j < 25) w[j*64 +: 64] = model_lane(4*k + j);
    end
    return w;
  endfunction

  // Drive one lane for a single cycle and update the reference model.
  task automatic send(input int x, input int y, input bit pi, input int sel, input logic [63:0] lane);
    logic [255:0] d;
    int xd, yd, idx;
    bit bad;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    d[sel*64 +: 64] = lane;
    check("in_ready_before_send", bus.in_ready, 1);
    bus.in_valid   = 1'b1;
    bus.in_data    = d;
    bus.in_d_w_sel = 2'(sel);
    bus.in_x       = 3'(x);
    bus.in_y       = 3'(y);
    bus.in_pi      = pi;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bad = (x > 4) || (y > 4);
    if (!bad) begin
      xd  = pi ? y : x;
      yd  = pi ? (2*x + 3*y) % 5 : y;
      idx = xd + 5*yd;
      mdl[idx] = lane;
      if (!mbm[idx]) begin
        mbm[idx] = 1'b1;
        mcnt++;
      end
    end
    check("err_after_send", bus.err, bad);
    check("lane_cnt", bus.lane_cnt, mcnt);
    check("out_valid_latency", bus.out_valid, mcnt == 25);
    if (mcnt == 25) begin
      for (int k = 0; k < 7; k++) exp_q.push_back(model_word(k));
      for (int i = 0; i < 25; i++) mbm[i] = 1'b0;
      mcnt = 0;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 25; i++) begin
      if (!mbm[i]) send(i % 5, i / 5, 1'b0, i % 4, {$urandom, $urandom});
    end
  endtask

  // Consume drain beats; optional stall (3 cycles) and flush at given beats (-1 = none).
  task automatic drain(input int stall_beat, input int flush_beat);
    logic [255:0] hold;
    logic [255:0] exp;
    bus.out_ready = 1'b1;
    for (int b = 0; b < 7; b++) begin
      check("out_valid_in_drain", bus.out_valid, 1);
      check("in_ready_in_drain", bus.in_ready, 0);
      if (b == stall_beat) begin
        bus.out_ready = 1'b0;
        hold = bus.out_data;
        repeat (3) begin
          @(posedge clk);
          #1;
          check("stall_valid", bus.out_valid, 1);
          check("stall_data", bus.out_data, hold);
        end
        bus.out_ready = 1'b1;
      end
      if (b == flush_beat) begin
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        check("flush_out_valid", bus.out_valid, 0);
        check("flush_in_ready", bus.in_ready, 1);
        check("flush_lane_cnt", bus.lane_cnt, 0);
        exp_q.delete();
        return;
      end
      check("sb_has_entry", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        check($sformatf("drain_word%0d", b), bus.out_data, exp);
      end
      check($sformatf("out_last_beat%0d", b), bus.out_last, b == 6);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b0;
    check("post_drain_out_valid", bus.out_valid, 0);
    check("post_drain_in_ready", bus.in_ready, 1);
    check("post_drain_lane_cnt", bus.lane_cnt, 0);
    for (int i = 0; i < 25; i++) mdl[i] = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] w2;
    for (int i = 0; i < 25; i++) begin
      mdl[i] = '0;
      mbm[i] = 1'b0;
    end
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_d_w_sel = '0;
    bus.in_x = '0; bus.in_y = '0; bus.in_pi = 1'b0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_err", bus.err, 0);
    check("rst_lane_cnt", bus.lane_cnt, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Round 1: indexed pattern, d_w_sel cycling
    for (int i = 0; i < 25; i++)
      send(i % 5, i / 5, 1'b0, i % 4, 64'h0000_0000_0000_0100 * i + 64'(i));
`ifndef OTBN_KECCAK_COLLECT_CHI_EN
    check("word0_direct", bus.out_data,
          {64'h0000_0000_0000_0303, 64'h0000_0000_0000_0202,
           64'h0000_0000_0000_0101, 64'h0000_0000_0000_0000});
`endif
    drain(-1, -1);

    // Round 2: pi remap, duplicate, out-of-range, stalled drain
    send(1, 0, 1'b1, 0, 64'hDEAD_BEEF_0000_0001);
    send(2, 3, 1'b0, 1, 64'hAAAA_0000_1111_2222);
    send(2, 3, 1'b0, 2, 64'hBBBB_3333_4444_5555);
    send(5, 0, 1'b0, 3, 64'h1234_5678_9ABC_DEF0);
    @(posedge clk);
    #1;
    check("err_one_cycle", bus.err, 0);
    check("lane_cnt_after_bad", bus.lane_cnt, 2);
    fill_random();
    w2 = exp_q.size() > 2 ? exp_q[2] : '0;
`ifndef OTBN_KECCAK_COLLECT_CHI_EN
    check("pi_lane_in_word2", w2[191:128], 64'hDEAD_BEEF_0000_0001);
`endif
    drain(2, -1);

    // Round 3: flush at beat 4, then refill from partial state
    fill_random();
    drain(-1, 4);
    send(0, 0, 1'b0, 0, 64'h0000_0000_0000_007B);
    check("cnt_after_flush_write", bus.lane_cnt, 1);
    fill_random();
    drain(1, -1);

`ifdef OTBN_KECCAK_COLLECT_CHI_EN
    // chi row 0 = {1,2,4,8,16}, rest zero
    for (int i = 0; i < 25; i++)
      send(i % 5, i / 5, 1'b0, 0, (i < 5) ? (64'd1 << i) : 64'd0);
    check("chi_lane0", {192'd0, bus.out_data[63:0]}, 256'd5);
    drain(-1, -1);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/otbn_keccak_lane_collector.md
Name: otbn_keccak_lane_collector

Overview:
- Receive side of the Keccak lane datapath. Accepts 256-bit WDR-formatted results, each carrying one 64-bit lane in slot d_w_sel, tagged with lane coordinates (x,y).
- Optionally remaps coordinates through the Keccak pi step, then scatters each lane into a 25-lane state buffer.
- Once all 25 lanes are present, streams the state back out as seven packed 256-bit words over a valid/ready handshake, for writeback to WDRs.

Parameters:
- LaneW, 64, lane width in bits. Only 64 is supported.
- WordW, 256, word width in bits. Must equal 4*LaneW.
- ClearOnDrain, 1: when 1, the lane buffer data is zeroed after the last drain beat. The presence bitmap and lane count clear regardless.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- in_valid_i  in  1  input lane valid
- in_ready_o  out  1  collector can accept a lane
- in_data_i  in  WordW  word containing the lane
- in_d_w_sel_i  in  2  slot holding the lane: bits [64*sel +: 64]
- in_x_i  in  3  lane column, 0..4
- in_y_i  in  3  lane row, 0..4
- in_pi_i  in  1  apply pi mapping to (x,y) before storing
- flush_i  in  1  synchronous abort; clears collection
- out_valid_o  out  1  drain word valid
- out_ready_i  in  1  sink accepts drain word
- out_data_o  out  WordW  packed lanes
- out_last_o  out  1  final drain word
- lane_cnt_o  out  5  number of distinct lanes collected, 0..25
- err_o  out  1  one-cycle pulse on a rejected input

Behaviour:
- Reset (async, rst_i=1):
  - State COLLECT; bitmap=0; lane_cnt_o=0; drain counter=0; buffer=0.
  - out_valid_o=0, out_last_o=0, err_o=0, in_ready_o=1 (out of reset).
- Lane index: idx = x + 5*y.
- Pi mapping when in_pi_i=1: destination (x',y') = (y, (2x+3y) mod 5). Example: (1,0) -> (0,2); (0,0) -> (0,0).
- COLLECT state:
  - in_ready_o=1. A handshake occurs when in_valid_i && in_ready_o.
  - On handshake, the selected lane is written to buffer[idx'] and bitmap[idx'] is set.
  - lane_cnt_o increments only if bitmap[idx'] was previously clear. A duplicate write overwrites data and the count is unchanged.
  - x>4 or y>4 (checked before pi): input is consumed, nothing is stored, err_o pulses in the next cycle.
  - When the handshake brings lane_cnt to 25, the next cycle is DRAIN.
- DRAIN state:
  - in_ready_o=0; out_valid_o=1.
  - Word k (k=0..6) = {lane[4k+3], lane[4k+2], lane[4k+1], lane[4k]}, with lane 0 in the LSBs.
  - Word 6 carries only lane 24 in bits [63:0]; its upper 192 bits are 0.
  - out_data_o is driven from the buffer for the current drain counter. It is held stable while out_valid_o && !out_ready_i.
  - The counter advances on each out handshake. out_last_o=1 when counter==6.
  - Last handshake: bitmap, lane_cnt_o and counter are cleared (buffer too if ClearOnDrain); the next cycle is COLLECT.
  - Drain latency: the first word is valid 1 cycle after the 25th lane is accepted. Seven beats at full throughput.
- flush_i (highest priority, either state):
  - Next cycle: COLLECT, bitmap=0, count=0, counter=0, out_valid_o=0.
  - Any same-cycle input or output handshake is ignored.
  - Buffer data is not cleared.
- Async reset asserted mid-drain returns immediately to the reset values.
- No backpressure deadlock: out_valid_o stays asserted until accepted; the collector never drops it.

Optional Feature:
- Macro OTBN_KECCAK_COLLECT_CHI_EN.
- Defined: drain words carry chi(state). Lane (x,y) = A[x,y] ^ (~A[(x+1)%5,y] & A[(x+2)%5,y]), computed combinationally from the full buffer. Packing and timing are unchanged.
- Undefined: the raw buffer is drained and the chi logic is absent.

Test Plan:
- Reset, then 25 writes with in_pi_i=0, lane (x,y) = 64'h0000_0000_0000_0100*idx+idx, d_w_sel cycling 0..3 -> lane_cnt_o reaches 25. Word0 = {lane3,lane2,lane1,lane0}; word6[63:0] = lane24 and its upper bits are 0; out_last_o only on beat 6.
- Write x=1,y=0 with in_pi_i=1 and data 64'hDEAD_BEEF_0000_0001 -> stored at idx 10 (x=0,y=2). Observed at drain word 2, bits [191:128].
- Write the same (2,3) twice with values A then B -> lane_cnt_o increments once; drain shows B.
- Input x=5,y=0 -> in_ready_o=1, handshake occurs, err_o=1 for one cycle, lane_cnt_o unchanged.
- During drain, hold out_ready_i=0 for 3 cycles at beat 2 -> out_data_o and out_valid_o are stable. Pulse flush_i at beat 4 -> COLLECT next cycle, lane_cnt_o=0, in_ready_o=1.
- With OTBN_KECCAK_COLLECT_CHI_EN defined: row 0 set to {1,2,4,8,16} and all other lanes 0 -> drained lane 0 = 1^(~2&4) = 5.
